// File: rtl/switch_alloc_pkg.sv
// Shared constants and types for the mesh-router switch allocator.
// Input port indices, default destination width and the per-output lock state.
package switch_alloc_pkg;

    localparam int PORT_X     = 2;
    localparam int PORT_Y     = 1;
    localparam int PORT_LOCAL = 0;

    localparam int DEF_DST_W = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

endpackage

// File: rtl/switch_alloc_out_arb.sv
// Per-output arbiter: round-robin pick among inputs addressing this output,
// packet lock to the head winner, and owner dst-violation detect.
module switch_alloc_out_arb
    import switch_alloc_pkg::*;
#(
    parameter int N_IN    = 3,
    parameter int DW      = DEF_DST_W,
    parameter int OUT_IDX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IN-1:0]    req_valid,
    input  logic [N_IN*DW-1:0] req_dst,
    input  logic [N_IN-1:0]    req_tail,
    input  logic               ready,
    output logic [N_IN-1:0]    grant,
    output logic               valid,
    output logic [1:0]         sel,
    output logic               locked,
    output logic               viol
);

    localparam logic [DW-1:0] MY_DST = DW'(OUT_IDX);

    out_state_e state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;

    logic [N_IN-1:0] hit;
    logic            found;
    logic [1:0]      win;
    logic            win_tail;
    logic            own_valid;
    logic            own_hit;
    logic            own_tail;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            hit[i] = req_valid[i] && (req_dst[i*DW +: DW] == MY_DST);
        end
    end

    // Candidate order starts just after the last winner and wraps back to it.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_tail = 1'b0;
        for (int k = 1; k <= N_IN; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (!found && hit[i] && ((int'(ptr_q) + k) % N_IN == i)) begin
                    found    = 1'b1;
                    win      = i[1:0];
                    win_tail = req_tail[i];
                end
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_hit   = 1'b0;
        own_tail  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (owner_q == i[1:0]) begin
                own_valid = req_valid[i];
                own_hit   = hit[i];
                own_tail  = req_tail[i];
            end
        end
    end

    always_comb begin
        grant   = '0;
        valid   = 1'b0;
        sel     = '0;
        viol    = 1'b0;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (ready && found) begin
                    for (int i = 0; i < N_IN; i++) begin
                        grant[i] = (win == i[1:0]);
                    end
                    valid = 1'b1;
                    sel   = win;
                    ptr_d = win;
                    if (!win_tail) begin
                        state_d = ST_LOCKED;
                        owner_d = win;
                    end
                end
            end
            ST_LOCKED: begin
                sel  = owner_q;
                viol = own_valid && !own_hit;
                if (own_hit && ready) begin
                    for (int i = 0; i < N_IN; i++) begin
                        grant[i] = (owner_q == i[1:0]);
                    end
                    valid = 1'b1;
                    if (own_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/switch_alloc.sv
// Switch allocator for one mesh router node: one packet-aware round-robin
// arbiter per output, grants merged per input, sticky protocol error flag.
module switch_alloc
    import switch_alloc_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4,
    parameter int DST_W = DEF_DST_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       req_valid,
    input  logic [N_IN*DST_W-1:0] req_dst,
    input  logic [N_IN-1:0]       req_tail,
    input  logic [N_OUT-1:0]      out_ready,
    output logic [N_IN-1:0]       grant,
    output logic [N_OUT-1:0]      out_valid,
    output logic [N_OUT*2-1:0]    out_sel,
    output logic [N_OUT-1:0]      locked,
    output logic                  err
);

    logic [N_IN-1:0]  grant_vec [N_OUT];
    logic [N_OUT-1:0] viol;
    logic             err_q;

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        switch_alloc_out_arb #(
            .N_IN    (N_IN),
            .DW      (DST_W),
            .OUT_IDX (o)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_dst   (req_dst),
            .req_tail  (req_tail),
            .ready     (out_ready[o]),
            .grant     (grant_vec[o]),
            .valid     (out_valid[o]),
            .sel       (out_sel[o*2 +: 2]),
            .locked    (locked[o]),
            .viol      (viol[o])
        );
    end

    // Each input addresses one output, so the per-output grants never overlap.
    always_comb begin
        grant = '0;
        for (int o = 0; o < N_OUT; o++) begin
            grant = grant | grant_vec[o];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|viol);
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_switch_alloc.sv
// Scoreboard bench for switch_alloc: stimulus pushes reference-model expectations,
// a negedge monitor pops and compares; directed scenarios then randomized packets.
module tb_switch_alloc;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_valid;
    logic [5:0] req_dst;
    logic [2:0] req_tail;
    logic [3:0] out_ready;
    logic [2:0] grant;
    logic [3:0] out_valid;
    logic [7:0] out_sel;
    logic [3:0] locked;
    logic       err;

    switch_alloc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .locked    (locked),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] grant;
        logic [3:0] valid;
        logic [7:0] sel;
        logic [3:0] locked;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: -1 means the output is free; last_m is the most recent winner.
    int owner_m [4];
    int last_m  [4];
    bit err_m;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            owner_m[o] = -1;
            last_m[o]  = 1;
        end
        err_m = 1'b0;
    endtask

    task automatic step(input logic [2:0] v, input logic [5:0] d, input logic [2:0] t,
                        input logic [3:0] r, output logic [2:0] g);
        exp_t       e;
        int         g_o;
        int         w;
        bit         err_nx;
        logic [1:0] sel_o;
        req_valid = v;
        req_dst   = d;
        req_tail  = t;
        out_ready = r;
        e.grant  = '0;
        e.valid  = '0;
        e.sel    = '0;
        e.locked = '0;
        e.err    = err_m;
        err_nx   = 1'b0;
        for (int o = 0; o < 4; o++) begin
            g_o = -1;
            e.locked[o] = (owner_m[o] >= 0);
            if (owner_m[o] >= 0) begin
                w = owner_m[o];
                if (v[w] && d[w*2 +: 2] == o[1:0]) begin
                    if (r[o]) g_o = w;
                end else if (v[w]) begin
                    err_nx = 1'b1;
                end
            end else if (r[o]) begin
                for (int k = 1; k <= 3; k++) begin
                    w = (last_m[o] + k) % 3;
                    if (g_o < 0 && v[w] && d[w*2 +: 2] == o[1:0]) g_o = w;
                end
            end
            if (g_o >= 0) begin
                e.grant[g_o] = 1'b1;
                e.valid[o]   = 1'b1;
            end
            sel_o = (owner_m[o] >= 0) ? 2'(owner_m[o]) : ((g_o >= 0) ? 2'(g_o) : 2'd0);
            e.sel[o*2 +: 2] = sel_o;
            if (g_o >= 0) begin
                last_m[o] = g_o;
                if (owner_m[o] < 0) begin
                    if (!t[g_o]) owner_m[o] = g_o;
                end else if (t[g_o]) begin
                    owner_m[o] = -1;
                end
            end
        end
        err_m = err_m | err_nx;
        g = e.grant;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_grant",     8'(grant),     8'(mon_e.grant));
            check("sb_out_valid", 8'(out_valid), 8'(mon_e.valid));
            check("sb_out_sel",   out_sel,       mon_e.sel);
            check("sb_locked",    8'(locked),    8'(mon_e.locked));
            check("sb_err",       8'(err),       8'(mon_e.err));
        end
    end

    logic [2:0] g;
    logic [2:0] t1_exp [4];
    logic [2:0] t2_exp [4];
    logic [2:0] t3_exp [4];
    logic [3:0] t3_rdy [4];
    logic [2:0] t3_tail [4];

    bit         act [3];
    int         rem [3];
    logic [1:0] rdst [3];
    logic [2:0] rv, rt;
    logic [5:0] rd;
    logic [3:0] rr;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_dst   = '0;
        req_tail  = '0;
        out_ready = '0;
        model_reset();
        #22 rst_n = 1'b1;
        tick();

        // Reset state under idle inputs.
        step(3'b000, 6'd0, 3'b000, 4'hf, g);
        tick();

        // Three single-flit requesters to dst 1: x, local, y, x.
        t1_exp = '{3'b100, 3'b001, 3'b010, 3'b100};
        for (int c = 0; c < 4; c++) begin
            step(3'b111, {2'd1, 2'd1, 2'd1}, 3'b111, 4'hf, g);
            check($sformatf("t1_grant_c%0d", c), 8'(grant), 8'(t1_exp[c]));
            tick();
        end

        // x 3-flit packet to dst 2 with y contending; y follows x's tail.
        t2_exp = '{3'b100, 3'b100, 3'b100, 3'b010};
        for (int c = 0; c < 4; c++) begin
            if (c < 3) step(3'b110, {2'd2, 2'd2, 2'd0}, {(c == 2), 2'b10}, 4'hf, g);
            else       step(3'b010, {2'd0, 2'd2, 2'd0}, 3'b010, 4'hf, g);
            check($sformatf("t2_grant_c%0d", c), 8'(grant), 8'(t2_exp[c]));
            if (c == 1 || c == 2) check($sformatf("t2_locked2_c%0d", c), 8'(locked[2]), 8'd1);
            tick();
        end

        // Output 0 locked to local; ready drops for two cycles.
        t3_exp  = '{3'b001, 3'b000, 3'b000, 3'b001};
        t3_rdy  = '{4'hf, 4'he, 4'he, 4'hf};
        t3_tail = '{3'b000, 3'b000, 3'b000, 3'b001};
        for (int c = 0; c < 4; c++) begin
            step(3'b001, {2'd0, 2'd0, 2'd0}, t3_tail[c], t3_rdy[c], g);
            check($sformatf("t3_grant_c%0d", c), 8'(grant), 8'(t3_exp[c]));
            if (c == 1 || c == 2) check($sformatf("t3_locked0_c%0d", c), 8'(locked[0]), 8'd1);
            tick();
        end

        // Independent outputs in one cycle.
        step(3'b110, {2'd0, 2'd3, 2'd0}, 3'b110, 4'hf, g);
        check("t4_grant", 8'(grant), 8'b110);
        check("t4_sel0", 8'(out_sel[1:0]), 8'd2);
        check("t4_sel3", 8'(out_sel[7:6]), 8'd1);
        tick();

        // Locked owner y changes dst mid-packet (output 2 not ready, so no grant anywhere).
        step(3'b010, {2'd0, 2'd1, 2'd0}, 3'b000, 4'hf, g);
        check("t5_head_grant", 8'(grant), 8'b010);
        tick();
        step(3'b010, {2'd0, 2'd2, 2'd0}, 3'b000, 4'b1011, g);
        check("t5_viol_grant", 8'(grant), 8'b000);
        tick();
        step(3'b000, 6'd0, 3'b000, 4'hf, g);
        check("t5_err_set", 8'(err), 8'd1);
        tick();
        step(3'b000, 6'd0, 3'b000, 4'hf, g);
        check("t5_err_sticky", 8'(err), 8'd1);
        tick();

        // Reset mid-packet on output 3.
        step(3'b100, {2'd3, 2'd0, 2'd0}, 3'b000, 4'hf, g);
        check("t6_head_grant", 8'(grant), 8'b100);
        tick();
        step(3'b000, 6'd0, 3'b000, 4'hf, g);
        check("t6_locked3", 8'(locked[3]), 8'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_locked_async", 8'(locked), 8'd0);
        check("t6_err_async", 8'(err), 8'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        tick();
        step(3'b111, {2'd3, 2'd3, 2'd3}, 3'b111, 4'hf, g);
        check("t6_fresh_grant", 8'(grant), 8'b100);
        tick();

        // Randomized protocol-abiding packets.
        for (int i = 0; i < 3; i++) begin
            act[i]  = 1'b0;
            rem[i]  = 0;
            rdst[i] = 2'd0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!act[i] && $urandom_range(0, 9) < 4) begin
                    act[i]  = 1'b1;
                    rem[i]  = $urandom_range(1, 4);
                    rdst[i] = 2'($urandom_range(0, 3));
                end
                rv[i]         = act[i];
                rt[i]         = (rem[i] == 1);
                rd[i*2 +: 2]  = rdst[i];
            end
            for (int o = 0; o < 4; o++) rr[o] = ($urandom_range(0, 3) != 0);
            step(rv, rd, rt, rr, g);
            for (int i = 0; i < 3; i++) begin
                if (g[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) act[i] = 1'b0;
                end
            end
            tick();
        end

        step(3'b000, 6'd0, 3'b000, 4'hf, g);
        tick();
        tick();
        check("sb_drain", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_alloc.md
# switch_alloc

Switch allocator for one mesh router node: arbitrates the three input ports (x, y, local) onto four output ports addressed by 2-bit destination, locks an output to its winner for the duration of a multi-flit packet, and rotates priority per output with a round-robin pointer. It sits between the input buffers and the crossbar, consuming the same x/y/local destination fields the conflict-detection stage compares and replacing that stage's pairwise fail logic with a per-output, packet-aware grant.

## Interface
- N_IN, 3, number of input ports; index 2 = x, 1 = y, 0 = local.
- N_OUT, 4, number of output ports.
- DST_W, 2, destination width; equals clog2(N_OUT).
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_IN  input i presents a flit.
- req_dst  in  N_IN*DST_W  destination of input i, bits [i*DST_W +: DST_W].
- req_tail  in  N_IN  flit of input i is last of its packet; a single-flit packet has tail high on its only flit.
- out_ready  in  N_OUT  output o can accept a flit this cycle.
- grant  out  N_IN  flit of input i transfers this cycle; at most one bit per output.
- out_valid  out  N_OUT  output o carries a flit this cycle.
- out_sel  out  N_OUT*2  crossbar select for output o, the index of the granted or owning input.
- locked  out  N_OUT  output o is mid-packet.
- err  out  1  sticky protocol-violation flag.

## Operation
- Transfer on input i happens when req_valid[i] && grant[i]; the flit goes to output req_dst[i].
- grant, out_valid, out_sel are combinational from the current state, req_*, and out_ready. locked and err are registered.
- Per-output state: IDLE or LOCKED, plus owner[1:0] and ptr[1:0] registers.
- Round-robin order from ptr: (ptr+1) mod 3, (ptr+2) mod 3, ptr. The first candidate in that order with req_valid high and req_dst equal to o wins.
- IDLE behaviour:
  - If out_ready[o] is low, there is no grant and the state holds.
  - Otherwise the winner w gets the grant and ptr is set to w.
  - If req_tail[w] is low, the output moves to LOCKED with owner set to w. If req_tail[w] is high, it stays IDLE.
- LOCKED behaviour:
  - Only the owner can be granted, and only when its req_valid is high, its req_dst equals o, and out_ready[o] is high.
  - A granted tail flit returns the output to IDLE; ptr stays equal to owner.
  - Other requesters to o wait.
- Protocol violations:
  - An owner presenting valid with a different dst while locked is not granted, and err is set.
  - A requester must hold dst and valid until granted. This is not checked.
- out_sel:
  - Shows the owner while locked.
  - Shows the winner in the cycle it is granted.
  - Otherwise shows the reset value.
- Each input requests exactly one output, so grant is never multiply driven.
- Reset values:
  - All outputs IDLE, owner = 0, ptr = 1, so the first order is x, local, y.
  - locked = 0 and err = 0.
  - grant, out_valid and out_sel evaluate to 0 under idle inputs.

## Timing
- Grant latency is 0 cycles: a request and a ready output in the same cycle produce the transfer in that cycle.
- Lock and ptr take effect the cycle after the head grant.
- Back-to-back packets from different inputs to the same output need no bubble. A tail in cycle t lets a new winner be granted in t+1.
- A tail flit and a new head to a different output from the same input in consecutive cycles are legal.
- When out_ready drops while LOCKED, the lock is held and the grant is withheld until out_ready returns.
- Asserting rst_n low mid-packet clears every lock immediately, asynchronously. After release, the partial packet's remaining flits are treated as new heads; upstream flushing is the source's responsibility.
- When several outputs resolve in the same cycle, each resolves independently.

## Structure
- The shared package holds:
  - the port index constants PORT_X = 2, PORT_Y = 1, PORT_LOCAL = 0;
  - the DST_W default;
  - the enumerated output-state type (IDLE, LOCKED).
- Sub-module out_arb: one instance per output port. It contains the state, owner, ptr, the 3-way round-robin pick and the violation detect.
- The top level generates N_OUT instances, ORs the per-output grant vectors into grant, and ORs the per-output error pulses into the sticky err.

## Test plan
- After reset, x, y and local all request dst 1 with tail=1 and out_ready all 1. Required grants: cycle 0 x, cycle 1 local, cycle 2 y, cycle 3 x.
- x sends a 3-flit packet to dst 2 while y also requests dst 2. Required: x is granted for 3 cycles, locked[2]=1 during flits 2–3, and y is granted in the cycle after x's tail.
- While output 0 is locked to local, out_ready[0] goes low for 2 cycles. Required: grant[0]=0 and locked[0]=1 hold during those cycles, and the transfer resumes when ready returns.
- Simultaneous x→dst 0 and y→dst 3, both single-flit. Required: both are granted in the same cycle, with out_sel[0]=2 and out_sel[3]=1.
- Locked owner y switches its dst mid-packet. Required: no grant, err=1 on the next edge and stays 1.
- rst_n pulses low while output 3 is locked. Required: locked[3]=0 immediately, ptr returns to 1, and the next request arbitrates afresh.
